// File: rtl/ysyx_22041211_lsu.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_22041211_lsu
// Purpose  : Load/store unit between the pipeline and a single-port SRAM.
//            It accepts one request at a time, performs a single-cycle SRAM
//            access, lane-aligns or extends the data, and holds the result
//            for writeback until it is accepted. Misaligned requests and
//            unknown op codes complete without touching memory.
// Ports    : clk, rst (async, active-low)
//            lsu_*_i / lsu_ready_o   : request handshake (op, addr, wdata, rd)
//            mem_*_o / mem_rdata_i   : SRAM port (combinational read data,
//                                      write commits on the clk edge)
//            wb_*_o  / wb_ready_i    : writeback handshake
// Revision : 1.0 - initial release
// ============================================================================
module ysyx_22041211_lsu #(
    parameter int ADDR_LEN = 32,
    parameter int DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lsu_valid_i,
    output logic                lsu_ready_o,
    input  logic [3:0]          lsu_op_i,
    input  logic [ADDR_LEN-1:0] lsu_addr_i,
    input  logic [DATA_LEN-1:0] lsu_wdata_i,
    input  logic [4:0]          lsu_rd_i,
    output logic                mem_ren_o,
    output logic                mem_wen_o,
    output logic [ADDR_LEN-1:0] mem_raddr_o,
    output logic [ADDR_LEN-1:0] mem_waddr_o,
    output logic [DATA_LEN-1:0] mem_wdata_o,
    output logic [7:0]          mem_wmask_o,
    output logic [7:0]          mem_rmask_o,
    input  logic [DATA_LEN-1:0] mem_rdata_i,
    output logic                wb_valid_o,
    input  logic                wb_ready_i,
    output logic [DATA_LEN-1:0] wb_rdata_o,
    output logic [4:0]          wb_rd_o,
    output logic                wb_is_load_o,
    output logic                wb_misalign_o
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic [3:0]          op_q;
    logic [ADDR_LEN-1:0] addr_q;
    logic [DATA_LEN-1:0] wdata_q;
    logic [4:0]          rd_q;
    logic [DATA_LEN-1:0] result_q;
    logic                is_load_q;
    logic                misalign_q;

    // ---------------- incoming request decode ----------------
    logic req_known, req_load, req_misalign, accept;

    always_comb begin
        req_known = 1'b0;
        req_load  = 1'b0;
        case (lsu_op_i)
            4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b0101: begin
                req_known = 1'b1;
                req_load  = 1'b1;
            end
            4'b1000, 4'b1001, 4'b1010: req_known = 1'b1;
            default: ;
        endcase
        req_misalign = req_known &
                       (((lsu_op_i[1:0] == 2'b01) & lsu_addr_i[0]) |
                        ((lsu_op_i[1:0] == 2'b10) & (lsu_addr_i[1:0] != 2'b00)));
    end

    // Ready is also gated by rst so that every output reads 0 during reset.
    assign lsu_ready_o = (state_q == S_IDLE) & rst;
    assign accept      = lsu_valid_i & lsu_ready_o;

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // ---------------- lane helpers for the latched request ----------------
    logic [4:0]          shamt;
    logic [7:0]          lane_mask;
    logic [DATA_LEN-1:0] store_trim;
    logic [DATA_LEN-1:0] load_lane;
    logic [DATA_LEN-1:0] load_ext;

    assign shamt     = {addr_q[1:0], 3'b000};
    assign load_lane = mem_rdata_i >> shamt;

    always_comb begin
        case (op_q[1:0])
            2'b00:   lane_mask = 8'h01 << addr_q[1:0];
            2'b01:   lane_mask = 8'h03 << addr_q[1:0];
            default: lane_mask = 8'h0F;
        endcase

        // Trim store data to its size so lanes outside the mask stay 0.
        case (op_q[1:0])
            2'b00:   store_trim = {{(DATA_LEN-8){1'b0}},  wdata_q[7:0]};
            2'b01:   store_trim = {{(DATA_LEN-16){1'b0}}, wdata_q[15:0]};
            default: store_trim = wdata_q;
        endcase

        case (op_q)
            4'b0000: load_ext = {{(DATA_LEN-8){load_lane[7]}},   load_lane[7:0]};
            4'b0001: load_ext = {{(DATA_LEN-16){load_lane[15]}}, load_lane[15:0]};
            4'b0100: load_ext = {{(DATA_LEN-8){1'b0}},  load_lane[7:0]};
            4'b0101: load_ext = {{(DATA_LEN-16){1'b0}}, load_lane[15:0]};
            default: load_ext = load_lane;
        endcase
    end

    // ---------------- next state and outputs ----------------
    always_comb begin
        state_d     = state_q;
        mem_ren_o   = 1'b0;
        mem_wen_o   = 1'b0;
        mem_raddr_o = '0;
        mem_waddr_o = '0;
        mem_wdata_o = '0;
        mem_rmask_o = 8'h00;
        mem_wmask_o = 8'h00;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    // Faults and unknown ops skip the memory cycle entirely.
                    state_d = (req_known & ~req_misalign) ? S_ACCESS : S_RESP;
                end
            end
            S_ACCESS: begin
                state_d = S_RESP;
                if (op_q[3]) begin
                    mem_wen_o   = 1'b1;
                    mem_waddr_o = {addr_q[ADDR_LEN-1:2], 2'b00};
                    mem_wdata_o = store_trim << shamt;
                    mem_wmask_o = lane_mask;
                end else begin
                    mem_ren_o   = 1'b1;
                    mem_raddr_o = {addr_q[ADDR_LEN-1:2], 2'b00};
                    mem_rmask_o = lane_mask;
                end
            end
            S_RESP: begin
                if (wb_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------- request / result registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q       <= 4'b0000;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= 5'd0;
            result_q   <= '0;
            is_load_q  <= 1'b0;
            misalign_q <= 1'b0;
        end else if (accept) begin
            op_q       <= lsu_op_i;
            addr_q     <= lsu_addr_i;
            wdata_q    <= lsu_wdata_i;
            rd_q       <= lsu_rd_i;
            result_q   <= '0;
            is_load_q  <= req_load;
            misalign_q <= req_misalign;
        end else if ((state_q == S_ACCESS) && !op_q[3]) begin
            result_q   <= load_ext;
        end
    end

    assign wb_valid_o    = (state_q == S_RESP);
    assign wb_rdata_o    = wb_valid_o ? result_q : '0;
    assign wb_rd_o       = wb_valid_o ? rd_q : 5'd0;
    assign wb_is_load_o  = wb_valid_o & is_load_q;
    assign wb_misalign_o = wb_valid_o & misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_22041211_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_ysyx_22041211_lsu
// Purpose  : Directed self-checking bench for the load/store unit. Expected
//            values are hand-computed constants; SRAM writes are recorded by
//            a small monitor so aborted stores can be detected.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ysyx_22041211_lsu;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        lsu_valid_i = 1'b0;
    logic        lsu_ready_o;
    logic [3:0]  lsu_op_i = 4'b0;
    logic [31:0] lsu_addr_i = '0;
    logic [31:0] lsu_wdata_i = '0;
    logic [4:0]  lsu_rd_i = '0;
    logic        mem_ren_o, mem_wen_o;
    logic [31:0] mem_raddr_o, mem_waddr_o, mem_wdata_o;
    logic [7:0]  mem_wmask_o, mem_rmask_o;
    logic [31:0] mem_rdata_i = '0;
    logic        wb_valid_o;
    logic        wb_ready_i = 1'b1;
    logic [31:0] wb_rdata_o;
    logic [4:0]  wb_rd_o;
    logic        wb_is_load_o, wb_misalign_o;

    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    logic [31:0] wr_addr = '0;
    logic [31:0] wr_data = '0;

    ysyx_22041211_lsu #(.ADDR_LEN(32), .DATA_LEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .lsu_valid_i  (lsu_valid_i),
        .lsu_ready_o  (lsu_ready_o),
        .lsu_op_i     (lsu_op_i),
        .lsu_addr_i   (lsu_addr_i),
        .lsu_wdata_i  (lsu_wdata_i),
        .lsu_rd_i     (lsu_rd_i),
        .mem_ren_o    (mem_ren_o),
        .mem_wen_o    (mem_wen_o),
        .mem_raddr_o  (mem_raddr_o),
        .mem_waddr_o  (mem_waddr_o),
        .mem_wdata_o  (mem_wdata_o),
        .mem_wmask_o  (mem_wmask_o),
        .mem_rmask_o  (mem_rmask_o),
        .mem_rdata_i  (mem_rdata_i),
        .wb_valid_o   (wb_valid_o),
        .wb_ready_i   (wb_ready_i),
        .wb_rdata_o   (wb_rdata_o),
        .wb_rd_o      (wb_rd_o),
        .wb_is_load_o (wb_is_load_o),
        .wb_misalign_o(wb_misalign_o)
    );

    always #5 clk = ~clk;

    // SRAM write monitor: a write exists only if wen is high at a clock edge.
    always @(posedge clk) begin
        if (mem_wen_o) begin
            wr_cnt  = wr_cnt + 1;
            wr_addr = mem_waddr_o;
            wr_data = mem_wdata_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Advance one cycle; sample point is 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present a request for one cycle; returns in the cycle after acceptance.
    task automatic issue(input logic [3:0] op, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [4:0] rd);
        lsu_valid_i = 1'b1;
        lsu_op_i    = op;
        lsu_addr_i  = addr;
        lsu_wdata_i = wdata;
        lsu_rd_i    = rd;
        step();
        lsu_valid_i = 1'b0;
    endtask

    initial begin
        // ---- reset state ----
        step();
        check("rst_ready",  {31'b0, lsu_ready_o}, 32'd0);
        check("rst_wbv",    {31'b0, wb_valid_o},  32'd0);
        check("rst_ren",    {31'b0, mem_ren_o},   32'd0);
        check("rst_wen",    {31'b0, mem_wen_o},   32'd0);
        rst = 1'b1;
        step();
        check("idle_ready", {31'b0, lsu_ready_o}, 32'd1);

        // ---- LB sign extend, lane 3 ----
        mem_rdata_i = 32'h85001122;
        issue(4'b0000, 32'h80000003, 32'h0, 5'd7);
        check("lb_ren",    {31'b0, mem_ren_o},  32'd1);
        check("lb_wen",    {31'b0, mem_wen_o},  32'd0);
        check("lb_raddr",  mem_raddr_o,         32'h80000000);
        check("lb_rmask",  {24'b0, mem_rmask_o}, 32'h08);
        check("lb_wbv_n1", {31'b0, wb_valid_o}, 32'd0);
        check("lb_rdy_n1", {31'b0, lsu_ready_o}, 32'd0);
        step();
        check("lb_wbv",    {31'b0, wb_valid_o},  32'd1);
        check("lb_data",   wb_rdata_o,           32'hFFFFFF85);
        check("lb_rd",     {27'b0, wb_rd_o},     32'd7);
        check("lb_isld",   {31'b0, wb_is_load_o}, 32'd1);
        check("lb_mis",    {31'b0, wb_misalign_o}, 32'd0);
        check("lb_ren_r",  {31'b0, mem_ren_o},   32'd0);
        step();
        check("lb_idle",   {31'b0, lsu_ready_o}, 32'd1);
        check("lb_wbv_off", {31'b0, wb_valid_o}, 32'd0);

        // ---- LHU zero extend, upper half ----
        mem_rdata_i = 32'h9ABC1234;
        issue(4'b0101, 32'h80000002, 32'h0, 5'd3);
        check("lhu_rmask", {24'b0, mem_rmask_o}, 32'h0C);
        step();
        check("lhu_data",  wb_rdata_o, 32'h00009ABC);
        step();

        // ---- LH sign extend, lower half ----
        mem_rdata_i = 32'h00008001;
        issue(4'b0001, 32'h80000000, 32'h0, 5'd4);
        check("lh_rmask",  {24'b0, mem_rmask_o}, 32'h03);
        step();
        check("lh_data",   wb_rdata_o, 32'hFFFF8001);
        step();

        // ---- SB, lane 1 ----
        issue(4'b1000, 32'h80000001, 32'h000000AA, 5'd0);
        check("sb_wen",    {31'b0, mem_wen_o},  32'd1);
        check("sb_ren",    {31'b0, mem_ren_o},  32'd0);
        check("sb_wmask",  {24'b0, mem_wmask_o}, 32'h02);
        check("sb_wdata",  mem_wdata_o,         32'h0000AA00);
        check("sb_waddr",  mem_waddr_o,         32'h80000000);
        step();
        check("sb_wen_off", {31'b0, mem_wen_o}, 32'd0);
        check("sb_wrcnt",  wr_cnt,              32'd1);
        check("sb_wrdata", wr_data,             32'h0000AA00);
        check("sb_wbv",    {31'b0, wb_valid_o}, 32'd1);
        check("sb_rdata",  wb_rdata_o,          32'd0);
        check("sb_isld",   {31'b0, wb_is_load_o}, 32'd0);
        step();

        // ---- SH with junk upper bits, lane 2 ----
        issue(4'b1001, 32'h80000012, 32'hFFFF5678, 5'd0);
        check("sh_wmask",  {24'b0, mem_wmask_o}, 32'h0C);
        check("sh_wdata",  mem_wdata_o,         32'h56780000);
        step();
        step();

        // ---- misaligned SW: fault path ----
        issue(4'b1010, 32'h80000002, 32'h11223344, 5'd9);
        check("sw_mis_wbv",  {31'b0, wb_valid_o},    32'd1);
        check("sw_mis_flag", {31'b0, wb_misalign_o}, 32'd1);
        check("sw_mis_wen",  {31'b0, mem_wen_o},     32'd0);
        check("sw_mis_data", wb_rdata_o,             32'd0);
        step();
        check("sw_mis_wrcnt", wr_cnt, 32'd2);
        check("sw_mis_idle", {31'b0, lsu_ready_o}, 32'd1);

        // ---- unknown op: no-access completion ----
        issue(4'b0011, 32'h80000000, 32'h0, 5'd5);
        check("unk_wbv",   {31'b0, wb_valid_o},    32'd1);
        check("unk_mis",   {31'b0, wb_misalign_o}, 32'd0);
        check("unk_isld",  {31'b0, wb_is_load_o},  32'd0);
        check("unk_data",  wb_rdata_o,             32'd0);
        step();

        // ---- LW with writeback back-pressure ----
        wb_ready_i  = 1'b0;
        mem_rdata_i = 32'hDEADBEEF;
        issue(4'b0010, 32'h80000004, 32'h0, 5'd12);
        check("lw_rmask", {24'b0, mem_rmask_o}, 32'h0F);
        step();
        mem_rdata_i = 32'h0BADF00D;
        for (int i = 0; i < 3; i++) begin
            check("lw_hold_wbv",  {31'b0, wb_valid_o},  32'd1);
            check("lw_hold_data", wb_rdata_o,           32'hDEADBEEF);
            check("lw_hold_rd",   {27'b0, wb_rd_o},     32'd12);
            check("lw_hold_rdy",  {31'b0, lsu_ready_o}, 32'd0);
            if (i == 2) wb_ready_i = 1'b1;
            step();
        end
        check("lw_idle",   {31'b0, lsu_ready_o}, 32'd1);
        check("lw_wbv_off", {31'b0, wb_valid_o}, 32'd0);

        // ---- reset during ACCESS of an SW ----
        issue(4'b1010, 32'h80000008, 32'h12345678, 5'd1);
        check("abort_wen",   {31'b0, mem_wen_o},   32'd1);
        check("abort_wdata", mem_wdata_o,          32'h12345678);
        #2;
        rst = 1'b0;
        #1;
        check("abort_wen0",  {31'b0, mem_wen_o},   32'd0);
        check("abort_rdy0",  {31'b0, lsu_ready_o}, 32'd0);
        check("abort_wdat0", mem_wdata_o,          32'd0);
        step();
        rst = 1'b1;
        #1;
        check("abort_wrcnt", wr_cnt,               32'd2);
        check("abort_rdy1",  {31'b0, lsu_ready_o}, 32'd1);
        step();
        check("abort_nowb",  {31'b0, wb_valid_o},  32'd0);

        // ---- back-to-back throughput: 3 cycles per request ----
        lsu_valid_i = 1'b1;
        lsu_op_i    = 4'b0100;
        lsu_addr_i  = 32'h80000000;
        lsu_rd_i    = 5'd2;
        mem_rdata_i = 32'h000000F0;
        step();
        check("tp_c1_ready", {31'b0, lsu_ready_o}, 32'd0);
        step();
        check("tp_c2_wbv",   {31'b0, wb_valid_o},  32'd1);
        check("tp_c2_data",  wb_rdata_o,           32'h000000F0);
        step();
        check("tp_c3_ready", {31'b0, lsu_ready_o}, 32'd1);
        lsu_valid_i = 1'b0;
        step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ysyx_22041211_lsu.md
YSYX_22041211_LSU -- requirements
Module: ysyx_22041211_lsu

Interface
REQ-001 SHALL have parameter ADDR_LEN, default 32, meaning address width.
REQ-002 SHALL have parameter DATA_LEN, default 32, meaning data width.
REQ-003 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset; asynchronous, active-low.
REQ-005 SHALL have port lsu_valid_i  in  1  upstream request valid.
REQ-006 SHALL have port lsu_ready_o  out  1  LSU can accept a request.
REQ-007 SHALL have port lsu_op_i  in  4  op: 0000 LB, 0001 LH, 0010 LW, 0100 LBU, 0101 LHU, 1000 SB, 1001 SH, 1010 SW.
REQ-008 SHALL have port lsu_addr_i  in  ADDR_LEN  byte address.
REQ-009 SHALL have port lsu_wdata_i  in  DATA_LEN  store data, right-aligned.
REQ-010 SHALL have port lsu_rd_i  in  5  destination register tag.
REQ-011 SHALL have port mem_ren_o  out  1  SRAM read enable; data returns combinationally.
REQ-012 SHALL have port mem_wen_o  out  1  SRAM write enable; write commits on the clk edge.
REQ-013 SHALL have port mem_raddr_o / mem_waddr_o  out  ADDR_LEN  word-aligned address {addr[31:2],2'b00}.
REQ-014 SHALL have port mem_wdata_o  out  DATA_LEN  lane-shifted store data.
REQ-015 SHALL have port mem_wmask_o / mem_rmask_o  out  8  byte-lane masks.
REQ-016 SHALL have port mem_rdata_i  in  DATA_LEN  raw word from SRAM.
REQ-017 SHALL have port wb_valid_o  out  1  result valid to writeback.
REQ-018 SHALL have port wb_ready_i  in  1  writeback accepts result.
REQ-019 SHALL have port wb_rdata_o  out  DATA_LEN  extended load data; 0 for stores and faults.
REQ-020 SHALL have port wb_rd_o  out  5  tag of the completing request.
REQ-021 SHALL have port wb_is_load_o  out  1  completing op is a load.
REQ-022 SHALL have port wb_misalign_o  out  1  request was misaligned; no memory access was made.

Function
REQ-023 SHALL implement FSM IDLE -> ACCESS -> RESP -> IDLE, with a direct IDLE -> RESP path for faulting requests.
REQ-024 SHALL assert lsu_ready_o only in IDLE; on lsu_valid_i&lsu_ready_o, SHALL latch op, addr, wdata and rd.
REQ-025 SHALL treat LH/LHU/SH with addr[0]=1, and LW/SW with addr[1:0]!=0, as misaligned: go IDLE->RESP, set wb_misalign_o=1, assert no ren/wen.
REQ-026 SHALL treat unlisted op codes as a no-access completion: go IDLE->RESP, wb_misalign_o=0, wb_rdata_o=0, wb_is_load_o=0.
REQ-027 In ACCESS, SHALL assert exactly one of mem_ren_o (loads) or mem_wen_o (stores) for exactly one cycle; both SHALL be 0 in every other state.
REQ-028 SHALL set masks from addr[1:0]=k: byte 8'h01<<k, half 8'h03<<k, word 8'h0F; a mask is 0 whenever its enable is 0.
REQ-029 SHALL drive mem_wdata_o = lsu_wdata_i << (8*k), with unused lanes 0.
REQ-030 In ACCESS for loads, SHALL extract lane k of mem_rdata_i and sign-extend (LB/LH) or zero-extend (LBU/LHU/LW) it into the result register at that cycle's edge.
REQ-031 SHALL hold wb_valid_o=1 in RESP, with wb_* outputs stable until wb_ready_i=1; it SHALL return to IDLE on that edge.
REQ-032 Latency: accepted at edge N -> ACCESS in cycle N+1 -> wb_valid_o from cycle N+2, provided it is not a fault; faults give wb_valid_o from cycle N+1.
REQ-033 SHALL accept no new request while ACCESS or RESP is active; back-to-back throughput SHALL be one request per 3 cycles when wb_ready_i=1.

Reset
REQ-034 While rst=0, SHALL force state IDLE and all outputs to 0; lsu_ready_o SHALL become 1 after rst deasserts.
REQ-035 Reset asserted during ACCESS SHALL abort immediately; a store whose edge is not reached SHALL not be written, and no wb_valid_o SHALL be produced for the aborted request.

Verification
REQ-036 SHALL cover this case: LB at addr 0x80000003 with mem_rdata_i=0x85001122 -> mem_raddr_o=0x80000000, mem_rmask_o=0x08, wb_rdata_o=0xFFFFFF85 at cycle N+2.
REQ-037 SHALL cover this case: LHU at 0x80000002 with mem_rdata_i=0x9ABC1234 -> mem_rmask_o=0x0C, wb_rdata_o=0x00009ABC.
REQ-038 SHALL cover this case: SB at 0x80000001 with wdata 0x000000AA -> mem_wen_o high for 1 cycle, mem_wmask_o=0x02, mem_wdata_o=0x0000AA00, wb_rdata_o=0.
REQ-039 SHALL cover this case: SW at 0x80000002 -> no wen, wb_valid_o at N+1, wb_misalign_o=1.
REQ-040 SHALL cover this case: LW completes with wb_ready_i held 0 for 3 cycles -> wb_* stable, lsu_ready_o=0 throughout, return to IDLE on the first ready edge.
REQ-041 SHALL cover this case: rst pulsed low during ACCESS of an SW -> outputs 0 immediately, no write recorded, lsu_ready_o=1 after release.
